// File: rtl/sort8_pkg.sv
// sort8_pkg: shared constants and types for the 8-lane pipelined sorting network.
//   SORT8_LANES / SORT8_LAYERS : network geometry
//   SORT8_PAIRS                : compare-and-swap (a,b) lane pairs per layer, padded to 4 slots
//   SORT8_LAYER_SIZE           : number of live pairs in each layer
//   stage_ctl_t                : per-stage control (valid, desc)
//   sort8_slot()               : elaboration-time lookup of the pair slot driving a lane
package sort8_pkg;

   localparam int unsigned SORT8_LANES     = 8;
   localparam int unsigned SORT8_LAYERS    = 6;
   localparam int unsigned SORT8_MAX_PAIRS = 4;

   localparam int unsigned SORT8_LAYER_SIZE [SORT8_LAYERS] = '{4, 4, 4, 2, 2, 3};

   // [layer][slot][0] = lane a (receives lo), [layer][slot][1] = lane b (receives hi).
   // Slots beyond SORT8_LAYER_SIZE are padding and never instantiated.
   localparam int unsigned SORT8_PAIRS [SORT8_LAYERS][SORT8_MAX_PAIRS][2] = '{
      '{'{0, 2}, '{1, 3}, '{4, 6}, '{5, 7}},
      '{'{0, 4}, '{1, 5}, '{2, 6}, '{3, 7}},
      '{'{0, 1}, '{2, 3}, '{4, 5}, '{6, 7}},
      '{'{2, 4}, '{3, 5}, '{0, 0}, '{0, 0}},
      '{'{1, 4}, '{3, 6}, '{0, 0}, '{0, 0}},
      '{'{1, 2}, '{3, 4}, '{5, 6}, '{0, 0}}
   };

   typedef struct packed {
      logic valid;
      logic desc;
   } stage_ctl_t;

   // Slot index whose side (0 = a, 1 = b) is the given lane in the given layer, or -1
   // when the lane is not touched by that side of any comparator in the layer.
   function automatic int sort8_slot(int unsigned layer, int unsigned lane, int unsigned side);
      sort8_slot = -1;
      for (int unsigned p = 0; p < SORT8_MAX_PAIRS; p++) begin
         if (p < SORT8_LAYER_SIZE[layer[2:0]] &&
             SORT8_PAIRS[layer[2:0]][p[1:0]][side[0]] == lane)
            sort8_slot = int'(p);
      end
   endfunction

endpackage

// File: rtl/sort8_pipe_if.sv
// sort8_pipe_if: valid/ready stream bundle for sort8_pipe.
//   in_valid/in_ready/in_data/in_tag[/in_desc] : producer side
//   out_valid/out_ready/out_data/out_tag       : consumer side
//   master : drives vectors in and consumes sorted vectors (producer + consumer)
//   slave  : the sorter itself
// in_desc exists only when SORT8_DESC_EN is defined.
interface sort8_pipe_if
   import sort8_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 8
);

   logic                            in_valid;
   logic                            in_ready;
   logic [SORT8_LANES*DATA_W-1:0]   in_data;
   logic [TAG_W-1:0]                in_tag;
`ifdef SORT8_DESC_EN
   logic                            in_desc;
`endif
   logic                            out_valid;
   logic                            out_ready;
   logic [SORT8_LANES*DATA_W-1:0]   out_data;
   logic [TAG_W-1:0]                out_tag;

`ifdef SORT8_DESC_EN
   modport master (
      output in_valid, in_data, in_tag, in_desc, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );
   modport slave (
      input  in_valid, in_data, in_tag, in_desc, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
`else
   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );
   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
`endif

endinterface

// File: rtl/sort8_cas.sv
// sort8_cas: combinational compare-and-swap on two unsigned elements.
//   a, b  : inputs (a is the lower-numbered lane)
//   desc  : 0 = lo gets min / hi gets max, 1 = lo gets max / hi gets min
//   lo,hi : outputs for lane a and lane b
// Equal inputs pass straight through.
module sort8_cas #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              desc,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] hi
);

   logic swap;

   always_comb begin
      swap = desc ? (a < b) : (b < a);
      lo   = swap ? b : a;
      hi   = swap ? a : b;
   end

endmodule

// File: rtl/sort8_pipe.sv
// sort8_pipe: 6-stage pipelined 8-lane sorting network (19 comparators) with
// valid/ready handshake and per-stage back-pressure.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears all stages
//   bus   : sort8_pipe_if.slave (in_valid/in_ready/in_data/in_tag[/in_desc],
//           out_valid/out_ready/out_data/out_tag)
// Build option SORT8_DESC_EN: adds in_desc and a per-vector sort direction
// carried down the pipe; without it the sorter is ascending only.
module sort8_pipe
   import sort8_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   sort8_pipe_if.slave  bus
);

   typedef logic [DATA_W-1:0] elem_t;
   typedef logic [TAG_W-1:0]  tag_t;

   elem_t                   lane_in  [SORT8_LAYERS][SORT8_LANES];
   elem_t                   lane_nx  [SORT8_LAYERS][SORT8_LANES];
   elem_t                   lane_q   [SORT8_LAYERS][SORT8_LANES];
   tag_t                    tag_in   [SORT8_LAYERS];
   tag_t                    tag_q    [SORT8_LAYERS];
   stage_ctl_t              ctl_q    [SORT8_LAYERS];
   logic [SORT8_LAYERS-1:0] up_valid;
   logic [SORT8_LAYERS-1:0] dir_in;
   logic [SORT8_LAYERS-1:0] vld;
   logic [SORT8_LAYERS-1:0] load;

`ifdef SORT8_DESC_EN
   assign dir_in[0] = bus.in_desc;
`else
   assign dir_in[0] = 1'b0;
`endif
   assign up_valid[0] = bus.in_valid;
   assign tag_in[0]   = bus.in_tag;

   for (genvar s = 0; s < SORT8_LAYERS; s++) begin : g_stage
      assign vld[s] = ctl_q[s].valid;
      // Stage s may load when every stage from s to the output is either empty or
      // the output is taken; this is the bubble-collapsing ready chain unrolled.
      assign load[s] = bus.out_ready | ~(&vld[SORT8_LAYERS-1:s]);

      if (s == 0) begin : g_first
         for (genvar i = 0; i < SORT8_LANES; i++) begin : g_lane
            assign lane_in[0][i] = bus.in_data[i*DATA_W +: DATA_W];
         end
      end else begin : g_chain
         assign up_valid[s] = ctl_q[s-1].valid;
         assign dir_in[s]   = ctl_q[s-1].desc;
         assign tag_in[s]   = tag_q[s-1];
         for (genvar i = 0; i < SORT8_LANES; i++) begin : g_lane
            assign lane_in[s][i] = lane_q[s-1][i];
         end
      end
   end

   // Comparator layers built from the package table; untouched lanes pass through.
   for (genvar l = 0; l < SORT8_LAYERS; l++) begin : g_layer
      elem_t lo [SORT8_MAX_PAIRS];
      elem_t hi [SORT8_MAX_PAIRS];

      for (genvar p = 0; p < SORT8_MAX_PAIRS; p++) begin : g_pair
         if (p < SORT8_LAYER_SIZE[l]) begin : g_cas
            sort8_cas #(.DATA_W(DATA_W)) u_cas (
               .a    (lane_in[l][SORT8_PAIRS[l][p][0]]),
               .b    (lane_in[l][SORT8_PAIRS[l][p][1]]),
               .desc (dir_in[l]),
               .lo   (lo[p]),
               .hi   (hi[p])
            );
         end else begin : g_pad
            assign lo[p] = '0;
            assign hi[p] = '0;
         end
      end

      for (genvar i = 0; i < SORT8_LANES; i++) begin : g_route
         localparam int SLOT_A = sort8_slot(l, i, 0);
         localparam int SLOT_B = sort8_slot(l, i, 1);
         if (SLOT_A >= 0) begin : g_a
            assign lane_nx[l][i] = lo[SLOT_A];
         end else if (SLOT_B >= 0) begin : g_b
            assign lane_nx[l][i] = hi[SLOT_B];
         end else begin : g_thru
            assign lane_nx[l][i] = lane_in[l][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < SORT8_LAYERS; s++) begin
            ctl_q[s[2:0]] <= '0;
            tag_q[s[2:0]] <= '0;
            for (int unsigned i = 0; i < SORT8_LANES; i++)
               lane_q[s[2:0]][i[2:0]] <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < SORT8_LAYERS; s++) begin
            if (load[s[2:0]]) begin
               ctl_q[s[2:0]].valid <= up_valid[s[2:0]];
               // Payload only moves with a real vector; a bubble leaves it as-is.
               if (up_valid[s[2:0]]) begin
                  ctl_q[s[2:0]].desc <= dir_in[s[2:0]];
                  tag_q[s[2:0]]      <= tag_in[s[2:0]];
                  lane_q[s[2:0]]     <= lane_nx[s[2:0]];
               end
            end
         end
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = ctl_q[SORT8_LAYERS-1].valid;
   assign bus.out_tag   = tag_q[SORT8_LAYERS-1];

   for (genvar i = 0; i < SORT8_LANES; i++) begin : g_out
      assign bus.out_data[i*DATA_W +: DATA_W] = lane_q[SORT8_LAYERS-1][i];
   end

endmodule

// File: tb/tb_sort8_pipe.sv
// tb_sort8_pipe: scoreboard bench for sort8_pipe. Accepted vectors are sorted by a
// queue-based reference and queued; an independent monitor pops and compares each
// emitted vector. Descending cases run only when SORT8_DESC_EN is defined.
module tb_sort8_pipe;
   import sort8_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned TW = 8;
   localparam int unsigned VW = SORT8_LANES * DW;

   typedef logic [VW-1:0] vec_t;
   typedef struct {
      vec_t          data;
      logic [TW-1:0] tag;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned not_ready_cycles = 0;

   sort8_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

   sort8_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t ref_sort(vec_t v, bit desc);
      logic [DW-1:0] q[$];
      vec_t          r;
      for (int i = 0; i < 8; i++) q.push_back(v[i*DW +: DW]);
      if (desc) q.rsort();
      else      q.sort();
      r = '0;
      for (int i = 0; i < 8; i++) r[i*DW +: DW] = q[i];
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < 8; i++)
         v[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 7);
      return v;
   endfunction

   task automatic check(string name, bit ok, logic [VW-1:0] act, logic [VW-1:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else    $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic send(vec_t d, logic [TW-1:0] t, bit desc);
      int unsigned waitc = 0;
      bit          done  = 0;
      while (!done) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         bus.in_tag   = t;
`ifdef SORT8_DESC_EN
         bus.in_desc  = desc;
`endif
         #1;
         if (bus.in_ready) begin
            sb.push_back('{data: ref_sort(d, desc), tag: t});
            done = 1;
         end else begin
            not_ready_cycles++;
            waitc++;
            if (waitc > 50) begin
               check("accept_timeout", 1'b0, 0, 1);
               done = 1;
            end
         end
      end
   endtask

   task automatic drain(string name);
      int unsigned c = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (sb.size() != 0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      check(name, sb.size() == 0, sb.size(), 0);
   endtask

   task automatic latency_check(string name);
      int unsigned lat = 0;
      do begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         lat++;
      end while (!bus.out_valid && lat < 20);
      check(name, lat == 6, lat, 6);
   endtask

   // Monitor: compares every emitted vector against the scoreboard head and
   // checks that a stalled output holds still.
   initial begin : monitor
      exp_t          e;
      bit            stalled = 0;
      vec_t          held_d  = '0;
      logic [TW-1:0] held_t  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            stalled = 0;
         end else begin
            if (stalled)
               check("stall_hold", bus.out_valid && bus.out_data == held_d && bus.out_tag == held_t,
                     bus.out_data, held_d);
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", 1'b0, bus.out_data, 0);
               end else begin
                  e = sb.pop_front();
                  check("out_data", bus.out_data == e.data, bus.out_data, e.data);
                  check("out_tag", bus.out_tag == e.tag, bus.out_tag, e.tag);
               end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held_d  = bus.out_data;
            held_t  = bus.out_tag;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin : stim
      vec_t        v;
      vec_t        base;
      int unsigned base_l[8] = '{7, 3, 9, 0, 5, 5, 1, 8};
      int unsigned acc;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
`ifdef SORT8_DESC_EN
      bus.in_desc   = 1'b0;
`endif

      // Reset state
      #7;
      check("rst_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
      check("rst_out_data",  bus.out_data == '0, bus.out_data, 0);
      check("rst_out_tag",   bus.out_tag == '0, bus.out_tag, 0);
      check("rst_in_ready",  bus.in_ready == 1'b1, bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single directed vector: latency, result, and out_valid dropping afterwards
      for (int i = 0; i < 8; i++) base[i*DW +: DW] = base_l[i];
      send(base, 8'hA5, 1'b0);
      latency_check("latency_first");
      @(negedge clk);
      check("valid_drop", bus.out_valid == 1'b0, bus.out_valid, 0);
      drain("drain_single");

      // Back-to-back stream, tags 0..99
      not_ready_cycles = 0;
      for (int n = 0; n < 100; n++) begin
         bit d = 1'b0;
`ifdef SORT8_DESC_EN
         d = ($urandom_range(0, 1) == 1);
`endif
         send(rand_vec(), TW'(n), d);
      end
      check("stream_in_ready", not_ready_cycles == 0, not_ready_cycles, 0);
      drain("drain_stream");

      // Back-pressure: consumer stalls for 10 cycles while the producer pushes
      @(negedge clk);
      bus.out_ready = 1'b0;
      acc = 0;
      v = rand_vec();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = v;
         bus.in_tag   = TW'(200 + acc);
`ifdef SORT8_DESC_EN
         bus.in_desc  = 1'b0;
`endif
         #1;
         if (bus.in_ready) begin
            sb.push_back('{data: ref_sort(v, 1'b0), tag: TW'(200 + acc)});
            acc++;
            v = rand_vec();
         end
      end
      check("stall_accepts", acc == 6, acc, 6);
      check("stall_in_ready", bus.in_ready == 1'b0, bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain("drain_backpressure");

`ifdef SORT8_DESC_EN
      // Mixed directions in flight together
      send(base, 8'h11, 1'b1);
      send(base, 8'h12, 1'b0);
      drain("drain_desc");
`endif

      // Extremes and ties
      v = '1;
      send(v, 8'hE0, 1'b0);
      for (int i = 0; i < 8; i++) v[i*DW +: DW] = (i % 2 == 1) ? '1 : '0;
      send(v, 8'hE1, 1'b0);
      for (int i = 0; i < 8; i++) v[i*DW +: DW] = (i % 2 == 0) ? '1 : '0;
      send(v, 8'hE2, 1'b0);
      drain("drain_extremes");

      // Mid-stream reset with vectors stalled in the pipe
      @(negedge clk);
      bus.out_ready = 1'b0;
      for (int n = 0; n < 4; n++) send(rand_vec() | vec_t'(1), TW'(240 + n), 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
      check("async_rst_data",  bus.out_data == '0, bus.out_data, 0);
      check("async_rst_tag",   bus.out_tag == '0, bus.out_tag, 0);
      check("async_rst_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      send(rand_vec(), 8'h77, 1'b0);
      latency_check("latency_after_reset");
      drain("drain_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
